// File: rtl/fir_tap_feeder_if.sv
// Sample-in / tap-pair-out stream bundle for fir_tap_feeder.
// slave = the feeder itself, master = the upstream/MAC side driving it.
interface fir_tap_feeder_if #(
    parameter int unsigned DW = 16
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_x;
    logic [DW-1:0] m_b;
    logic          m_first;
    logic          m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_x, m_b, m_first, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_x, m_b, m_first, m_last
    );
endinterface

// File: rtl/fir_tap_feeder.sv
// FIR feeder: circular delay line plus coefficient store; streams TAPS (x, b) pairs per sample.
// Define FIR_FEED_OVERLAP_EN to accept the next sample on the last transfer (no idle bubble).
module fir_tap_feeder #(
    parameter int unsigned TAPS = 64,
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 6
) (
    input  logic            clk,
    input  logic            reset,
    fir_tap_feeder_if.slave bus,
    input  logic            coef_we_i,
    input  logic [AW-1:0]   coef_addr_i,
    input  logic [DW-1:0]   coef_wdata_i,
    output logic            coef_err_o,
    output logic            busy_o
);
    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    localparam logic [AW-1:0] KLast = AW'(TAPS - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] dline_q [TAPS];
    logic [DW-1:0] cmem_q  [TAPS];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] k_q, k_d;
    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_x_q, m_x_d;
    logic [DW-1:0] m_b_q, m_b_d;
    logic          coef_err_q, coef_err_d;

    logic          s_ready;
    logic          accept;
    logic          xfer;
    logic          k_last;
    logic          cmem_we;
    logic [DW-1:0] coef0;
    logic [AW-1:0] k_nxt;
    logic [AW-1:0] rd_idx;

    assign xfer   = m_valid_q && bus.m_ready;
    assign k_last = (k_q == KLast);

`ifdef FIR_FEED_OVERLAP_EN
    assign s_ready = (state_q == StIdle) || (xfer && k_last);
`else
    assign s_ready = (state_q == StIdle);
`endif

    assign accept  = bus.s_valid && s_ready;
    assign cmem_we = coef_we_i && (state_q == StIdle);
    // Same-cycle write to address 0 must reach tap 0 of the burst being started.
    assign coef0   = (cmem_we && (coef_addr_i == '0)) ? coef_wdata_i : cmem_q[0];
    assign k_nxt   = k_q + 1'b1;
    assign rd_idx  = head_q - k_nxt;

    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        head_d     = head_q;
        k_d        = k_q;
        m_valid_d  = m_valid_q;
        m_x_d      = m_x_q;
        m_b_d      = m_b_q;
        coef_err_d = coef_we_i && (state_q == StBurst);

        if (accept) begin
            head_d    = wp_q;
            wp_d      = wp_q + 1'b1;
            k_d       = '0;
            m_valid_d = 1'b1;
            m_x_d     = bus.s_data;
            m_b_d     = coef0;
            state_d   = StBurst;
        end else if ((state_q == StBurst) && xfer) begin
            if (!k_last) begin
                k_d   = k_nxt;
                m_x_d = dline_q[rd_idx];
                m_b_d = cmem_q[k_nxt];
            end else begin
                m_valid_d = 1'b0;
                state_d   = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wp_q       <= '0;
            head_q     <= '0;
            k_q        <= '0;
            m_valid_q  <= 1'b0;
            m_x_q      <= '0;
            m_b_q      <= '0;
            coef_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            head_q     <= head_d;
            k_q        <= k_d;
            m_valid_q  <= m_valid_d;
            m_x_q      <= m_x_d;
            m_b_q      <= m_b_d;
            coef_err_q <= coef_err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                dline_q[i] <= '0;
                cmem_q[i]  <= '0;
            end
        end else begin
            if (accept) begin
                dline_q[wp_q] <= bus.s_data;
            end
            if (cmem_we) begin
                cmem_q[coef_addr_i] <= coef_wdata_i;
            end
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_x     = m_x_q;
    assign bus.m_b     = m_b_q;
    assign bus.m_first = m_valid_q && (k_q == '0);
    assign bus.m_last  = m_valid_q && k_last;
    assign coef_err_o  = coef_err_q;
    assign busy_o      = (state_q == StBurst);
endmodule

// File: tb/tb_fir_tap_feeder.sv
// Directed self-checking bench for fir_tap_feeder (TAPS=64, DW=16).
module tb_fir_tap_feeder;
    logic        clk = 1'b0;
    logic        reset;
    logic        coef_we;
    logic [5:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        coef_err;
    logic        busy;

    int nchecks = 0;
    int nerr    = 0;

    logic [15:0] cap_x [64];
    logic [15:0] cap_b [64];
    logic        cap_first [64];
    logic        cap_last [64];
    int          n_beats;
    int          sready_low;
    int          busy_hi;
    int          stall_changes;
    int          err_pulses;
    bit          timed_out;

    fir_tap_feeder_if #(.DW(16)) bus ();

    fir_tap_feeder #(.TAPS(64), .DW(16), .AW(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .coef_we_i   (coef_we),
        .coef_addr_i (coef_addr),
        .coef_wdata_i(coef_wdata),
        .coef_err_o  (coef_err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic write_coef(input logic [5:0] addr, input logic [15:0] data);
        coef_we = 1'b1; coef_addr = addr; coef_wdata = data;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    // Pushes one sample and records every transferred beat; no checking here.
    task automatic run_burst(input logic [15:0] sample, input bit stall, input int inj_beat);
        bit done = 0, was_stalled = 0, mr;
        logic [15:0] px = '0, pb = '0;
        logic pf = 0, pl = 0;
        int cyc = 0;
        n_beats = 0; sready_low = 0; busy_hi = 0; stall_changes = 0; err_pulses = 0;
        bus.s_valid = 1'b1; bus.s_data = sample; bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        while (!done && cyc < 400) begin
            coef_we = 1'b0;
            if (coef_err) err_pulses++;
            if (!bus.s_ready) sready_low++;
            if (busy) busy_hi++;
            if (bus.m_valid) begin
                if (was_stalled && (bus.m_x !== px || bus.m_b !== pb ||
                                    bus.m_first !== pf || bus.m_last !== pl)) stall_changes++;
                mr = stall ? cyc[0] : 1'b1;
                if (inj_beat == n_beats) begin
                    coef_we = 1'b1; coef_addr = 6'd5; coef_wdata = 16'h7FFF;
                    inj_beat = -1;
                end
                if (mr) begin
                    if (n_beats < 64) begin
                        cap_x[n_beats] = bus.m_x; cap_b[n_beats] = bus.m_b;
                        cap_first[n_beats] = bus.m_first; cap_last[n_beats] = bus.m_last;
                    end
                    n_beats++;
                end
                was_stalled = !mr;
                px = bus.m_x; pb = bus.m_b; pf = bus.m_first; pl = bus.m_last;
                bus.m_ready = mr;
            end else if (n_beats > 0) begin
                done = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        coef_we = 1'b0;
        bus.m_ready = 1'b1;
        timed_out = !done;
    endtask

    task automatic test_reset();
        reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        nchecks++; if (bus.m_valid !== 1'b0) begin nerr++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
        nchecks++; if (bus.s_ready !== 1'b1) begin nerr++; $display("FAIL rst_s_ready: got %b want 1", bus.s_ready); end
        nchecks++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
        nchecks++; if (coef_err !== 1'b0) begin nerr++; $display("FAIL rst_coef_err: got %b want 0", coef_err); end
        nchecks++; if (bus.m_x !== 16'h0 || bus.m_b !== 16'h0) begin
            nerr++; $display("FAIL rst_data: got x=%h b=%h want 0 0", bus.m_x, bus.m_b);
        end
        nchecks++; if (bus.m_first !== 1'b0 || bus.m_last !== 1'b0) begin
            nerr++; $display("FAIL rst_flags: got first=%b last=%b want 0 0", bus.m_first, bus.m_last);
        end
    endtask

    task automatic test_basic_burst();
        for (int i = 0; i < 64; i++) write_coef(6'(i), 16'(i + 1));
        run_burst(16'h0100, 1'b0, -1);
        nchecks++; if (timed_out) begin nerr++; $display("FAIL basic_timeout: got 1 want 0"); end
        nchecks++; if (n_beats !== 64) begin nerr++; $display("FAIL basic_beats: got %0d want 64", n_beats); end
        nchecks++; if (sready_low !== 64) begin nerr++; $display("FAIL basic_sready_low: got %0d want 64", sready_low); end
        nchecks++; if (busy_hi !== 64) begin nerr++; $display("FAIL basic_busy: got %0d want 64", busy_hi); end
        for (int i = 0; i < 64; i++) begin
            nchecks++;
            if (cap_x[i] !== ((i == 0) ? 16'h0100 : 16'h0000) || cap_b[i] !== 16'(i + 1) ||
                cap_first[i] !== (i == 0) || cap_last[i] !== (i == 63)) begin
                nerr++;
                $display("FAIL basic_beat[%0d]: got x=%h b=%h f=%b l=%b want x=%h b=%h f=%b l=%b", i,
                         cap_x[i], cap_b[i], cap_first[i], cap_last[i],
                         (i == 0) ? 16'h0100 : 16'h0000, 16'(i + 1), i == 0, i == 63);
            end
        end
    endtask

    task automatic test_wrap();
        for (int s = 1; s <= 65; s++) run_burst(16'(s), 1'b0, -1);
        nchecks++; if (timed_out || n_beats !== 64) begin
            nerr++; $display("FAIL wrap_beats: got %0d (timeout %b) want 64", n_beats, timed_out);
        end
        for (int i = 0; i < 64; i++) begin
            nchecks++;
            if (cap_x[i] !== 16'(65 - i) || cap_b[i] !== 16'(i + 1)) begin
                nerr++;
                $display("FAIL wrap_beat[%0d]: got x=%h b=%h want x=%h b=%h", i, cap_x[i], cap_b[i],
                         16'(65 - i), 16'(i + 1));
            end
        end
    endtask

    task automatic test_stall();
        run_burst(16'd66, 1'b1, -1);
        nchecks++; if (timed_out || n_beats !== 64) begin
            nerr++; $display("FAIL stall_beats: got %0d (timeout %b) want 64", n_beats, timed_out);
        end
        nchecks++; if (stall_changes !== 0) begin
            nerr++; $display("FAIL stall_hold: got %0d changes want 0", stall_changes);
        end
        for (int i = 0; i < 64; i++) begin
            nchecks++;
            if (cap_x[i] !== 16'(66 - i) || cap_b[i] !== 16'(i + 1) ||
                cap_first[i] !== (i == 0) || cap_last[i] !== (i == 63)) begin
                nerr++;
                $display("FAIL stall_beat[%0d]: got x=%h b=%h l=%b want x=%h b=%h l=%b", i, cap_x[i],
                         cap_b[i], cap_last[i], 16'(66 - i), 16'(i + 1), i == 63);
            end
        end
    endtask

    task automatic test_coef_write();
        run_burst(16'd67, 1'b0, 10);
        nchecks++; if (err_pulses !== 1) begin nerr++; $display("FAIL coef_err_pulse: got %0d cycles want 1", err_pulses); end
        run_burst(16'd68, 1'b0, -1);
        nchecks++; if (cap_b[5] !== 16'h0006) begin nerr++; $display("FAIL coef_busy_ignored: got %h want 0006", cap_b[5]); end
        nchecks++; if (err_pulses !== 0) begin nerr++; $display("FAIL coef_err_spurious: got %0d want 0", err_pulses); end
        write_coef(6'd5, 16'h7FFF);
        nchecks++; if (coef_err !== 1'b0) begin nerr++; $display("FAIL coef_err_idle: got %b want 0", coef_err); end
        run_burst(16'd69, 1'b0, -1);
        nchecks++; if (cap_b[5] !== 16'h7FFF || cap_b[4] !== 16'h0005 || cap_b[6] !== 16'h0007) begin
            nerr++; $display("FAIL coef_idle_write: got b4..6=%h %h %h want 0005 7fff 0007",
                             cap_b[4], cap_b[5], cap_b[6]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0, cyc = 0;
        bus.s_valid = 1'b1; bus.s_data = 16'd70; bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        while (n < 30 && cyc < 200) begin
            if (bus.m_valid) n++;
            @(posedge clk); #1;
            cyc++;
        end
        nchecks++; if (n !== 30) begin nerr++; $display("FAIL mid_reach30: got %0d want 30", n); end
        #2 reset = 1'b1;
        #1;
        nchecks++; if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin
            nerr++; $display("FAIL mid_async: got m_valid=%b busy=%b want 0 0", bus.m_valid, busy);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        nchecks++; if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            nerr++; $display("FAIL mid_release: got s_ready=%b m_valid=%b want 1 0", bus.s_ready, bus.m_valid);
        end
        run_burst(16'h0042, 1'b0, -1);
        nchecks++; if (timed_out || n_beats !== 64) begin
            nerr++; $display("FAIL mid_beats: got %0d want 64", n_beats);
        end
        for (int i = 0; i < 64; i++) begin
            nchecks++;
            if (cap_x[i] !== ((i == 0) ? 16'h0042 : 16'h0000) || cap_b[i] !== 16'h0000) begin
                nerr++;
                $display("FAIL mid_beat[%0d]: got x=%h b=%h want x=%h b=0000", i, cap_x[i], cap_b[i],
                         (i == 0) ? 16'h0042 : 16'h0000);
            end
        end
    endtask

    task automatic test_write_first();
        coef_we = 1'b1; coef_addr = 6'd0; coef_wdata = 16'h1234;
        run_burst(16'h0043, 1'b0, -1);
        nchecks++; if (cap_b[0] !== 16'h1234 || cap_b[1] !== 16'h0000) begin
            nerr++; $display("FAIL write_first_b: got b0=%h b1=%h want 1234 0000", cap_b[0], cap_b[1]);
        end
        nchecks++; if (cap_x[0] !== 16'h0043 || cap_x[1] !== 16'h0042 || cap_x[2] !== 16'h0000) begin
            nerr++; $display("FAIL write_first_x: got x0..2=%h %h %h want 0043 0042 0000",
                             cap_x[0], cap_x[1], cap_x[2]);
        end
    endtask

    task automatic test_back_to_back();
        int n_samp, exp_span, exp_gaps;
        int acc = 0, beats = 0, gaps = 0, span = 0, firsts = 0, badx = 0, cyc = 0;
        bit started = 0, acc_now;
`ifdef FIR_FEED_OVERLAP_EN
        n_samp = 10; exp_span = 640; exp_gaps = 0;
`else
        n_samp = 2;  exp_span = 129; exp_gaps = 1;
`endif
        bus.m_ready = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'h1000;
        while (beats < n_samp * 64 && cyc < 3000) begin
            if (bus.m_valid) begin
                started = 1;
                if (bus.m_first) begin
                    if (bus.m_x !== 16'(16'h1000 + firsts)) badx++;
                    firsts++;
                end
                beats++;
            end else if (started) begin
                gaps++;
            end
            if (started) span++;
            acc_now = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                acc++;
                if (acc == n_samp) bus.s_valid = 1'b0;
                else bus.s_data = 16'(16'h1000 + acc);
            end
        end
        bus.s_valid = 1'b0;
        nchecks++; if (beats !== n_samp * 64) begin nerr++; $display("FAIL b2b_beats: got %0d want %0d", beats, n_samp * 64); end
        nchecks++; if (span !== exp_span) begin nerr++; $display("FAIL b2b_span: got %0d want %0d", span, exp_span); end
        nchecks++; if (gaps !== exp_gaps) begin nerr++; $display("FAIL b2b_gaps: got %0d want %0d", gaps, exp_gaps); end
        nchecks++; if (firsts !== n_samp || badx !== 0) begin
            nerr++; $display("FAIL b2b_firsts: got %0d firsts %0d bad x want %0d and 0", firsts, badx, n_samp);
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_wrap();
        test_stall();
        test_coef_write();
        test_reset_mid_burst();
        test_write_first();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
